cpu_fetch: RTL
==============

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 The module SHALL have parameter BOOT_ADDRESS, default 32'h00001000, giving the first fetch byte address after reset.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk_i, input, 1: the only clock.
- rst_i, input, 1: asynchronous reset, active-high.
REQ-003 The module SHALL provide the following instruction-memory bus ports.
- imem_adr_o, output, 32: word-aligned fetch address; bits [1:0] always 0.
- imem_cyc_o, output, 1: bus cycle active.
- imem_stb_o, output, 1: request strobe.
- imem_dat_i, input, 32: read data; big-endian, so [31:16] is the lower halfword address.
- imem_ack_i, input, 1: read data valid; one-cycle pulse per request.
REQ-004 The module SHALL provide the following instruction FIFO write-side ports.
- data_o, output, 32: instruction-stream word.
- write_en_o, output, 1: write strobe, one cycle per word.
- full_i, input, 1: FIFO cannot accept a word.
- stall_i, input, 1: pipeline stall; treated exactly as full_i.
REQ-005 The module SHALL provide the following redirect ports.
- branch_flag_i, input, 1: redirect request.
- branch_target_i, input, 32: halfword-aligned target; bit 0 ignored.
- newPC_p_o, output, 1: one-cycle pulse announcing a new stream start.
- PC_o, output, 32: stream start address; valid while newPC_p_o=1.
- flush_o, output, 1: one-cycle pulse, coincident with newPC_p_o, that empties the FIFO.

Function
REQ-006 The FSM SHALL have four states: IDLE, REQ, HOLD, DISCARD.
REQ-007 IDLE is the reset state; on the first clock after reset release the FSM SHALL go to REQ and pulse newPC_p_o with PC_o=BOOT_ADDRESS.
REQ-008 In REQ, imem_cyc_o and imem_stb_o SHALL be 1, and imem_adr_o SHALL stay stable until imem_ack_i.
REQ-009 On ack in REQ with full_i=0, stall_i=0 and no redirect, write_en_o SHALL be 1 in the next cycle with the assembled word, imem_adr_o SHALL advance by 4, and the FSM SHALL stay in REQ (back-to-back fetch, one word per ack).
REQ-010 On ack in REQ with full_i=1 or stall_i=1, the word SHALL be latched into a hold register, cyc/stb SHALL drop, and the FSM SHALL go to HOLD.
REQ-011 In HOLD, the held word SHALL be written on the first cycle with full_i=0 and stall_i=0, and the FSM SHALL return to REQ at the next address.
REQ-012 write_en_o SHALL never be 1 while full_i=1 or stall_i=1.
REQ-013 A redirect (branch_flag_i=1) SHALL take priority over all other events.
- Any write pending that cycle SHALL be suppressed.
- Held data SHALL be discarded.
- newPC_p_o and flush_o SHALL pulse in the next cycle, with PC_o=branch_target_i & ~1.
- The fetch address SHALL become target & ~3.
REQ-014 A redirect while a request is outstanding without ack that cycle SHALL move the FSM to DISCARD.
- DISCARD keeps cyc/stb asserted until ack, drops that data, then enters REQ at the new address.
- A redirect arriving in DISCARD SHALL replace the pending target.
REQ-015 A redirect coinciding with ack SHALL drop the acked data and go directly to REQ at the new address.
REQ-016 If the target has bit 1 = 0, each fetched word SHALL be written unchanged.
REQ-017 If the target has bit 1 = 1, the fetch unit SHALL enter realign mode.
- First word: imem_dat_i[15:0] is saved in a 16-bit residue register and no write occurs.
- Each subsequent word: the unit writes {residue, imem_dat_i[31:16]} and saves imem_dat_i[15:0] as the new residue.
REQ-018 Realign mode SHALL persist until the next redirect.
REQ-019 Address arithmetic SHALL be 32-bit modulo 2^32; the increment from 32'hFFFFFFFC SHALL wrap to 0.

Reset
REQ-020 While rst_i=1, outputs SHALL hold these values:
- imem_cyc_o=0, imem_stb_o=0.
- imem_adr_o=BOOT_ADDRESS & ~3.
- write_en_o=0, data_o=0.
- newPC_p_o=0, flush_o=0, PC_o=BOOT_ADDRESS.
REQ-021 Reset while in REQ, HOLD or DISCARD SHALL clear the FSM, hold register, residue and realign flag immediately; a late ack after reset SHALL be ignored.

Structure
REQ-022 FSM state encodings and the default BOOT_ADDRESS SHALL live in a shared CPU package (cpu_defs).
REQ-023 The halfword realign datapath (residue register plus mux) SHALL be the single sub-module cpu_fetch_align; all other logic stays in cpu_fetch.

Verification
REQ-024 Reset release, memory acking every request with 0-cycle wait -> newPC_p_o with PC_o=32'h1000; writes of words at 0x1000, 0x1004, 0x1008 on consecutive cycles.
REQ-025 full_i=1 for 5 cycles while the ack for 0x1004 arrives -> no write_en_o during those cycles; cyc/stb low; the held word is written the cycle after full_i falls; the next fetch is 0x1008.
REQ-026 Redirect to 0x2000 while the 0x1008 request is outstanding with a 3-cycle ack delay -> the 0x1008 data is never written; flush_o and newPC_p_o pulse with PC_o=0x2000; the next imem_adr_o is 0x2000.
REQ-027 Redirect to 0x3002 with mem[0x3000]=0xAAAA1111 and mem[0x3004]=0x22223333 -> first write is data_o=0x11112222.
REQ-028 Redirect with the same-cycle ack, and a redirect during HOLD -> no stale write; the fetch restarts at the new target.
REQ-029 rst_i asserted mid-REQ followed by a late imem_ack_i -> the ack is ignored; the sequence matches REQ-024 after release.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, default boot address and
// small address-alignment helpers.
package cpu_defs;

    localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h00001000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] half_align(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/cpu_fetch_align.sv
// Halfword realignment of the fetched word stream: keeps the low halfword of
// each word as residue and splices it in front of the next word's high half.
module cpu_fetch_align (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        realign_i,
    input  logic        valid_i,
    input  logic [31:0] word_i,
    output logic        valid_o,
    output logic [31:0] word_o
);
    logic [15:0] residue_q, residue_d;
    logic        res_valid_q, res_valid_d;

    always_comb begin
        residue_d   = residue_q;
        res_valid_d = res_valid_q;
        if (clear_i) begin
            res_valid_d = 1'b0;
        end else if (valid_i && realign_i) begin
            residue_d   = word_i[15:0];
            res_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            residue_q   <= 16'h0000;
            res_valid_q <= 1'b0;
        end else begin
            residue_q   <= residue_d;
            res_valid_q <= res_valid_d;
        end
    end

    // The first word after entering realign mode only primes the residue.
    assign valid_o = valid_i && (!realign_i || res_valid_q);
    assign word_o  = realign_i ? {residue_q, word_i[31:16]} : word_i;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: streams words from the instruction bus into the
// instruction FIFO, with back-pressure holding and branch redirection.
module cpu_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = DEFAULT_BOOT_ADDRESS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_adr_o,
    output logic        imem_cyc_o,
    output logic        imem_stb_o,
    input  logic [31:0] imem_dat_i,
    input  logic        imem_ack_i,
    output logic [31:0] data_o,
    output logic        write_en_o,
    input  logic        full_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        newPC_p_o,
    output logic [31:0] PC_o,
    output logic        flush_o
);
    fetch_state_t state_q, state_d;

    logic [31:0] adr_q, adr_d;
    logic [31:0] pend_adr_q, pend_adr_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;
    logic        write_en_q, write_en_d;
    logic        newpc_q, newpc_d;
    logic        flush_q, flush_d;
    logic        realign_q, realign_d;

    logic        blocked;
    logic        outstanding;
    logic        align_valid;
    logic [31:0] align_in;
    logic        align_out_valid;
    logic [31:0] align_out;

    assign blocked     = full_i | stall_i;
    assign outstanding = (state_q == ST_REQ || state_q == ST_DISCARD) && !imem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_flag_i) begin
            state_d = outstanding ? ST_DISCARD : ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_REQ;
                ST_REQ:     if (imem_ack_i && blocked) state_d = ST_HOLD;
                ST_HOLD:    if (!blocked) state_d = ST_REQ;
                ST_DISCARD: if (imem_ack_i) state_d = ST_REQ;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_cyc_o = 1'b0;
        imem_stb_o = 1'b0;
        case (state_q)
            ST_REQ, ST_DISCARD: begin
                imem_cyc_o = 1'b1;
                imem_stb_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Word handed to the aligner: fresh bus data, or the held word on release.
    always_comb begin
        align_valid = 1'b0;
        align_in    = imem_dat_i;
        if (!branch_flag_i) begin
            case (state_q)
                ST_REQ:  align_valid = imem_ack_i && !blocked;
                ST_HOLD: begin
                    align_valid = !blocked;
                    align_in    = hold_q;
                end
                default: ;
            endcase
        end
    end

    cpu_fetch_align u_align (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (branch_flag_i),
        .realign_i (realign_q),
        .valid_i   (align_valid),
        .word_i    (align_in),
        .valid_o   (align_out_valid),
        .word_o    (align_out)
    );

    always_comb begin
        adr_d      = adr_q;
        pend_adr_d = pend_adr_q;
        hold_d     = hold_q;
        data_d     = data_q;
        pc_d       = pc_q;
        realign_d  = realign_q;
        write_en_d = 1'b0;
        newpc_d    = 1'b0;
        flush_d    = 1'b0;
        if (branch_flag_i) begin
            newpc_d   = 1'b1;
            flush_d   = 1'b1;
            pc_d      = half_align(branch_target_i);
            realign_d = branch_target_i[1];
            // Keep the bus address stable until the in-flight request is acked.
            if (outstanding) begin
                pend_adr_d = word_align(branch_target_i);
            end else begin
                adr_d = word_align(branch_target_i);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    newpc_d = 1'b1;
                    pc_d    = BOOT_ADDRESS;
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        adr_d = adr_q + 32'd4;
                        if (blocked) hold_d = imem_dat_i;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack_i) adr_d = pend_adr_q;
                end
                default: ;
            endcase
            write_en_d = align_out_valid;
            if (align_out_valid) data_d = align_out;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q      <= word_align(BOOT_ADDRESS);
            pend_adr_q <= word_align(BOOT_ADDRESS);
            hold_q     <= 32'h0;
            data_q     <= 32'h0;
            pc_q       <= BOOT_ADDRESS;
            realign_q  <= BOOT_ADDRESS[1];
            write_en_q <= 1'b0;
            newpc_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            adr_q      <= adr_d;
            pend_adr_q <= pend_adr_d;
            hold_q     <= hold_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            realign_q  <= realign_d;
            write_en_q <= write_en_d;
            newpc_q    <= newpc_d;
            flush_q    <= flush_d;
        end
    end

    assign imem_adr_o = adr_q;
    assign data_o     = data_q;
    assign write_en_o = write_en_q;
    assign newPC_p_o  = newpc_q;
    assign PC_o       = pc_q;
    assign flush_o    = flush_q;

endmodule
